// File: rtl/cmd_seq_proc_pkg.sv
// Shared types, timer widths and timing constants for the line-follower command sequencer.
package cmd_seq_pkg;

  typedef enum logic [2:0] {IDLE, MOVE, VEER, TURN_A, TURN_B, COLLISION} state_t;
  typedef enum logic [1:0] {OP_END, OP_VR, OP_VL, OP_TURN} op_t;

  localparam int TMR_W = 26;
  typedef logic [TMR_W-1:0] tmr_t;

  // FAST_SIM: 0 silicon, 1 short sim timing, >=2 the same ratios shrunk for unit benches
  function automatic tmr_t t1_cycles(input int fast_sim);
    if (fast_sim == 0) return tmr_t'(22) << 21;
    else if (fast_sim == 1) return tmr_t'(10) << 16;
    return tmr_t'(10) << 4;
  endfunction

  function automatic tmr_t t2_cycles(input int fast_sim);
    if (fast_sim == 0) return tmr_t'(31) << 21;
    else if (fast_sim == 1) return tmr_t'(16) << 16;
    return tmr_t'(16) << 4;
  endfunction

  function automatic tmr_t dbnc_cycles(input int fast_sim);
    if (fast_sim == 0) return tmr_t'(1) << 22;
    else if (fast_sim == 1) return tmr_t'(1) << 17;
    return tmr_t'(1) << 5;
  endfunction

  function automatic logic [15:0] signed_mag(input logic [15:0] mag, input logic right);
    return right ? mag : 16'(~mag + 16'd1);
  endfunction

endpackage

// File: rtl/cmd_seq_proc_if.sv
// Packet handshake between UART_wrapper (master) and the command sequencer (slave).
interface cmd_seq_proc_if #(parameter int CMD_W = 16);
  logic [CMD_W-1:0] cmd;
  logic             cmd_rdy;
  logic             clr_cmd_rdy;
  logic             fifo_full;

  modport master (output cmd, cmd_rdy, input clr_cmd_rdy, fifo_full);
  modport slave  (input cmd, cmd_rdy, output clr_cmd_rdy, fifo_full);
endinterface

// File: rtl/cmd_seq_proc_fifo.sv
// Synchronous packet FIFO; a pop always returns the pre-cycle head, a push never bypasses.
module cmd_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/cmd_seq_proc.sv
// Command sequencer: queues packets, walks 2-bit opcodes on line loss, handles bumper hits.
//  IDLE | no packet active    MOVE   | following line       VEER      | open-loop veer
//  TURN_A | first turn leg    TURN_B | second leg, then wait for line   COLLISION | bumper hit, buzzing
module cmd_seq_proc
  import cmd_seq_pkg::*;
#(
  parameter int          FAST_SIM   = 1,
  parameter int          CMD_W      = 16,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] VEER_MAG   = 16'h340,
  parameter logic [15:0] TURN1_MAG  = 16'h1E0,
  parameter logic [15:0] TURN2_MAG  = 16'h380
) (
  input  logic               clk,
  input  logic               rst_n,
  cmd_seq_proc_if.slave      cmd_bus,
  input  logic               line_present,
  input  logic               BMPL_n,
  input  logic               BMPR_n,
  output logic               go,
  output logic [15:0]        err_opn_lp,
  output logic               buzz,
  output logic               busy
);
  localparam tmr_t T1   = t1_cycles(FAST_SIM);
  localparam tmr_t T2   = t2_cycles(FAST_SIM);
  localparam tmr_t DBNC = dbnc_cycles(FAST_SIM);

  state_t           state, nxt_state;
  logic [CMD_W-1:0] cmd_reg, head;
  logic             last_veer_rght;
  tmr_t             tmr;
  logic             push, empty, full;
  logic             load, consume, clr_tmr, buzz_nxt;
  logic             bump, t1_done, t2_done, dbnc_done;
  op_t              op;

  assign op        = op_t'(cmd_reg[1:0]);
  assign bump      = !BMPL_n || !BMPR_n;
  assign t1_done   = (tmr >= T1);
  assign t2_done   = (tmr >= T2);
  assign dbnc_done = (tmr >= DBNC);
  assign busy      = (state != IDLE);

  // Gated by rst_n so no accept pulse escapes while reset is held
  assign push                = rst_n && cmd_bus.cmd_rdy && !full;
  assign cmd_bus.clr_cmd_rdy = push;
  assign cmd_bus.fifo_full   = full;

  cmd_fifo #(.W(CMD_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (load),
    .din   (cmd_bus.cmd),
    .head  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // Saturating timer keeps every threshold compare true until the next clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_reg        <= '0;
      last_veer_rght <= 1'b0;
      tmr            <= '0;
      buzz           <= 1'b0;
    end else begin
      if (load) begin
        cmd_reg <= head;
      end else if (consume) begin
        last_veer_rght <= cmd_reg[0];
        cmd_reg        <= {2'b00, cmd_reg[CMD_W-1:2]};
      end
      if (clr_tmr)      tmr <= '0;
      else if (~&tmr)   tmr <= tmr + 1'b1;
      buzz <= buzz_nxt;
    end
  end

  always_comb begin
    nxt_state = state;
    load      = 1'b0;
    consume   = 1'b0;
    clr_tmr   = 1'b0;
    buzz_nxt  = 1'b0;
    case (state)
      IDLE: if (!empty && line_present) begin
        load      = 1'b1;
        clr_tmr   = 1'b1;
        nxt_state = MOVE;
      end
      MOVE: begin
        if (line_present) begin
          if (bump) begin
            clr_tmr   = 1'b1;
            buzz_nxt  = 1'b1;
            nxt_state = COLLISION;
          end
        end else begin
          case (op)
            OP_TURN: begin
              clr_tmr   = 1'b1;
              nxt_state = TURN_A;
            end
            OP_VR, OP_VL: nxt_state = VEER;
            default: if (!empty) load = 1'b1;
                     else        nxt_state = IDLE;
          endcase
        end
      end
      VEER: if (line_present) begin
        consume   = 1'b1;
        nxt_state = MOVE;
      end
      TURN_A: if (t1_done) begin
        clr_tmr   = 1'b1;
        nxt_state = TURN_B;
      end
      TURN_B: if (t2_done && line_present) begin
        consume   = 1'b1;
        nxt_state = MOVE;
      end
      COLLISION: begin
        buzz_nxt = buzz;
        if (BMPL_n && BMPR_n) begin
          buzz_nxt  = 1'b0;
          nxt_state = MOVE;
        end else if (dbnc_done) begin
          buzz_nxt = !buzz;
          clr_tmr  = 1'b1;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_comb begin
    go         = 1'b0;
    err_opn_lp = 16'h0000;
    case (state)
      IDLE: go = !empty && line_present;
      MOVE: begin
        if (line_present) go = !bump;
        else              go = (op == OP_VR) || (op == OP_VL) || ((op == OP_END) && !empty);
      end
      VEER: begin
        go         = 1'b1;
        err_opn_lp = signed_mag(VEER_MAG, cmd_reg[0]);
      end
      TURN_A: begin
        go = !t1_done;
        if (!t1_done) err_opn_lp = signed_mag(TURN1_MAG, last_veer_rght);
      end
      TURN_B: begin
        go = 1'b1;
        if (!t2_done) err_opn_lp = signed_mag(TURN2_MAG, last_veer_rght);
      end
      default: begin
        go         = 1'b0;
        err_opn_lp = 16'h0000;
      end
    endcase
  end
endmodule

// File: tb/tb_cmd_seq_proc.sv
// Directed + randomized bench for cmd_seq_proc with a packet-level opcode model.
module tb_cmd_seq_proc;
  localparam int          CMD_W = 16;
  localparam int          DEPTH = 4;
  localparam int          T1    = 10 << 4;
  localparam int          T2    = 16 << 4;
  localparam logic [15:0] VEER  = 16'h0340;
  localparam logic [15:0] TN1   = 16'h01E0;
  localparam logic [15:0] TN2   = 16'h0380;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        line_present = 1'b0;
  logic        BMPL_n = 1'b1;
  logic        BMPR_n = 1'b1;
  logic        go, buzz, busy;
  logic [15:0] err;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] pend[$];
  logic [1:0]  cur[$];
  logic        last_right = 1'b0;

  cmd_seq_proc_if #(.CMD_W(CMD_W)) bus ();

  always #5 clk = ~clk;

  cmd_seq_proc #(
    .FAST_SIM   (2),
    .CMD_W      (CMD_W),
    .FIFO_DEPTH (DEPTH),
    .VEER_MAG   (VEER),
    .TURN1_MAG  (TN1),
    .TURN2_MAG  (TN2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_bus      (bus),
    .line_present (line_present),
    .BMPL_n       (BMPL_n),
    .BMPR_n       (BMPR_n),
    .go           (go),
    .err_opn_lp   (err),
    .buzz         (buzz),
    .busy         (busy)
  );

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_mag(input logic [15:0] m, input logic right);
    return right ? m : 16'h0000 - m;
  endfunction

  function automatic logic [15:0] rand_pkt();
    logic [15:0] p;
    int n;
    p = 16'h0000;
    n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) p[2*i +: 2] = 2'($urandom_range(1, 3));
    p = p | (16'($urandom) << (2 * (n + 1)));
    return p;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push_pkt(input logic [15:0] p);
    bus.cmd = p;
    bus.cmd_rdy = 1'b1;
    #1;
    chk1("clr_pulse", bus.clr_cmd_rdy, 1'b1);
    pend.push_back(p);
    step(1);
    bus.cmd_rdy = 1'b0;
    #1;
    chk1("clr_drop", bus.clr_cmd_rdy, 1'b0);
  endtask

  // Opcodes are read LSB pair first up to the first 00; anything above it is ignored
  task automatic load_model();
    logic [15:0] p;
    p = pend.pop_front();
    cur.delete();
    for (int i = 0; i < CMD_W/2; i++) begin
      if (p[2*i +: 2] == 2'b00) break;
      cur.push_back(p[2*i +: 2]);
    end
  endtask

  task automatic start_pkt();
    line_present = 1'b1;
    #1;
    chk1("idle_go", go, 1'b1);
    load_model();
    step(1);
    chk1("start_busy", busy, 1'b1);
  endtask

  task automatic walk();
    logic [1:0] o;
    logic       done;
    done = 1'b0;
    while (!done) begin
      line_present = 1'b0;
      #1;
      if (cur.size() == 0) begin
        if (pend.size() != 0) begin
          chk1("chain_go", go, 1'b1);
          step(1);
          chk1("chain_busy", busy, 1'b1);
          load_model();
        end else begin
          chk1("end_go", go, 1'b0);
          step(1);
          chk1("end_idle", busy, 1'b0);
          done = 1'b1;
        end
      end else begin
        o = cur.pop_front();
        if (o == 2'b11) begin
          chk1("turn_entry_go", go, 1'b0);
          step(1);
          chk16("turn_a_err", err, exp_mag(TN1, last_right));
          chk1("turn_a_go", go, 1'b1);
          step(T1 - 1);
          chk16("turn_a_last", err, exp_mag(TN1, last_right));
          step(1);
          chk1("turn_gap_go", go, 1'b0);
          chk16("turn_gap_err", err, 16'h0000);
          step(1);
          chk16("turn_b_err", err, exp_mag(TN2, last_right));
          chk1("turn_b_go", go, 1'b1);
          step(T2 - 1);
          chk16("turn_b_last", err, exp_mag(TN2, last_right));
          step(1);
          chk16("turn_b_done", err, 16'h0000);
          chk1("turn_wait_go", go, 1'b1);
          step(4);
          chk1("turn_wait_busy", busy, 1'b1);
        end else begin
          chk1("move_go", go, 1'b1);
          step(1);
          chk16("veer_err", err, exp_mag(VEER, o[0]));
          chk1("veer_go", go, 1'b1);
        end
        last_right = o[0];
        line_present = 1'b1;
        step(1);
        chk16("move_err", err, 16'h0000);
        chk1("move_busy", busy, 1'b1);
      end
    end
  endtask

  initial begin
    logic [15:0] p5;
    bus.cmd = 16'hFFFF;
    bus.cmd_rdy = 1'b1;
    #3;
    chk1("rst_clr", bus.clr_cmd_rdy, 1'b0);
    chk1("rst_go", go, 1'b0);
    chk16("rst_err", err, 16'h0000);
    chk1("rst_buzz", buzz, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_full", bus.fifo_full, 1'b0);
    step(2);
    rst_n = 1'b1;
    bus.cmd_rdy = 1'b0;
    step(1);

    // turn with no prior veer goes left
    push_pkt(16'h0003);
    start_pkt();
    walk();
    push_pkt(16'h0009);
    start_pkt();
    walk();
    push_pkt(16'h000D);
    start_pkt();
    walk();
    push_pkt(16'h000E);
    start_pkt();
    walk();

    for (int r = 0; r < 3; r++) begin
      push_pkt(rand_pkt());
      push_pkt(rand_pkt());
      start_pkt();
      walk();
    end

    // fill the FIFO, hold a fifth packet pending, release it with one pop
    push_pkt(rand_pkt());
    push_pkt(16'h0000);
    push_pkt(rand_pkt());
    push_pkt(rand_pkt());
    chk1("c_full", bus.fifo_full, 1'b1);
    p5 = rand_pkt();
    bus.cmd = p5;
    bus.cmd_rdy = 1'b1;
    #1;
    chk1("c_no_pulse", bus.clr_cmd_rdy, 1'b0);
    step(3);
    chk1("c_still_pending", bus.clr_cmd_rdy, 1'b0);
    line_present = 1'b1;
    #1;
    chk1("c_load_go", go, 1'b1);
    chk1("c_pop_no_pulse", bus.clr_cmd_rdy, 1'b0);
    load_model();
    step(1);
    chk1("c_busy", busy, 1'b1);
    chk1("c_full_drop", bus.fifo_full, 1'b0);
    chk1("c_pulse", bus.clr_cmd_rdy, 1'b1);
    pend.push_back(p5);
    step(1);
    bus.cmd_rdy = 1'b0;
    #1;
    chk1("c_full_again", bus.fifo_full, 1'b1);
    chk1("c_one_pulse", bus.clr_cmd_rdy, 1'b0);
    walk();

    // collision: buzz high on entry, toggles each debounce period
    push_pkt(16'h0001);
    start_pkt();
    BMPL_n = 1'b0;
    #1;
    chk1("e_entry_go", go, 1'b0);
    step(1);
    chk1("e_buzz_on", buzz, 1'b1);
    chk1("e_go", go, 1'b0);
    chk1("e_busy", busy, 1'b1);
    chk16("e_err", err, 16'h0000);
    push_pkt(rand_pkt());
    step(15);
    chk1("e_buzz_p0", buzz, 1'b1);
    step(33);
    chk1("e_buzz_p1", buzz, 1'b0);
    BMPL_n = 1'b1;
    BMPR_n = 1'b0;
    step(33);
    chk1("e_buzz_p2", buzz, 1'b1);
    chk1("e_still_go", go, 1'b0);
    BMPR_n = 1'b1;
    step(1);
    chk1("e_rel_buzz", buzz, 1'b0);
    chk1("e_rel_go", go, 1'b1);
    chk1("e_rel_busy", busy, 1'b1);
    walk();

    // reset in the middle of TURN_B with a full FIFO
    push_pkt(16'h000D);
    start_pkt();
    line_present = 1'b0;
    step(1);
    chk16("f_veer", err, 16'h0340);
    line_present = 1'b1;
    step(1);
    line_present = 1'b0;
    step(1);
    step(T1 + 1);
    chk16("f_turn_b", err, 16'h0380);
    for (int k = 0; k < DEPTH; k++) push_pkt(rand_pkt());
    chk1("f_full", bus.fifo_full, 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("f_rst_go", go, 1'b0);
    chk16("f_rst_err", err, 16'h0000);
    chk1("f_rst_buzz", buzz, 1'b0);
    chk1("f_rst_full", bus.fifo_full, 1'b0);
    chk1("f_rst_busy", busy, 1'b0);
    pend.delete();
    cur.delete();
    last_right = 1'b0;
    step(2);
    rst_n = 1'b1;
    line_present = 1'b1;
    step(5);
    chk1("f_no_resume_busy", busy, 1'b0);
    chk1("f_no_resume_go", go, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
